// File: rtl/attack_pkg.sv
// attack_pkg: state encoding, attack-word bit map and default frame counts shared with the damage lookup stage
package attack_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STARTUP,
      ST_ACTIVE,
      ST_RECOVERY
   } state_t;

   localparam int CONNECT   = 0;
   localparam int BUSY      = 1;
   localparam int A         = 5;
   localparam int UP_B      = 6;
   localparam int DOWN_B    = 7;
   localparam int SIDE_B_L  = 8;
   localparam int SIDE_B_R  = 9;
   localparam int NEUTRAL_B = 10;

   localparam logic [7:0] DEF_A_STARTUP  = 8'd2;
   localparam logic [7:0] DEF_A_ACTIVE   = 8'd3;
   localparam logic [7:0] DEF_A_RECOVERY = 8'd4;
   localparam logic [7:0] DEF_B_STARTUP  = 8'd4;
   localparam logic [7:0] DEF_B_ACTIVE   = 8'd4;
   localparam logic [7:0] DEF_B_RECOVERY = 8'd10;

   // B move one-hot relative to bit A, stick priority up > down > left > right > neutral
   function automatic logic [5:0] decode_b(input logic up, input logic down,
                                           input logic left, input logic right);
      logic [5:0] m;
      m = '0;
      if (up)         m[UP_B - A]      = 1'b1;
      else if (down)  m[DOWN_B - A]    = 1'b1;
      else if (left)  m[SIDE_B_L - A]  = 1'b1;
      else if (right) m[SIDE_B_R - A]  = 1'b1;
      else            m[NEUTRAL_B - A] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/attack_edge_detect.sv
// attack_edge_detect: rising-edge detector for both attack buttons, previous samples reset to 0
module attack_edge_detect (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn_a,
   input  logic i_btn_b,
   output logic o_rise_a,
   output logic o_rise_b
);

   logic [1:0] r_prev;

   // remember last cycle's button levels
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_prev <= 2'b00;
      else          r_prev <= {i_btn_b, i_btn_a};
   end

   assign o_rise_a = i_btn_a & ~r_prev[0];
   assign o_rise_b = i_btn_b & ~r_prev[1];

endmodule

// File: rtl/attack_encoder.sv
// attack_encoder: per-player move sequencer producing the attack word; ATTACK_BUFFER_EN adds a one-deep recovery input buffer
module attack_encoder
   import attack_pkg::*;
#(
   parameter logic [7:0] A_STARTUP  = DEF_A_STARTUP,
   parameter logic [7:0] A_ACTIVE   = DEF_A_ACTIVE,
   parameter logic [7:0] A_RECOVERY = DEF_A_RECOVERY,
   parameter logic [7:0] B_STARTUP  = DEF_B_STARTUP,
   parameter logic [7:0] B_ACTIVE   = DEF_B_ACTIVE,
   parameter logic [7:0] B_RECOVERY = DEF_B_RECOVERY
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_frame_tick,
   input  logic        i_btn_a,
   input  logic        i_btn_b,
   input  logic        i_stick_up,
   input  logic        i_stick_down,
   input  logic        i_stick_left,
   input  logic        i_stick_right,
   input  logic        i_hit,
   input  logic        i_stunned,
   output logic [31:0] o_attack
);

   state_t      r_state, w_state;
   logic [7:0]  r_cnt, w_cnt;
   logic [5:0]  r_move, w_move;
   logic        r_conn, w_conn;
   logic        r_strobe, w_strobe;
   logic        w_rise_a, w_rise_b, w_start;
   logic [5:0]  w_new_move;
   logic [31:0] w_word;
`ifdef ATTACK_BUFFER_EN
   logic        r_buf_v, w_buf_v;
   logic [5:0]  r_buf_move, w_buf_move;
`endif

   // move bit 0 of the 6-bit move vector is the A move
   function automatic logic [7:0] startup_of(input logic [5:0] m);
      return m[0] ? A_STARTUP : B_STARTUP;
   endfunction

   function automatic logic [7:0] active_of(input logic [5:0] m);
      return m[0] ? A_ACTIVE : B_ACTIVE;
   endfunction

   function automatic logic [7:0] recovery_of(input logic [5:0] m);
      return m[0] ? A_RECOVERY : B_RECOVERY;
   endfunction

   attack_edge_detect u_edge (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_btn_a  (i_btn_a),
      .i_btn_b  (i_btn_b),
      .o_rise_a (w_rise_a),
      .o_rise_b (w_rise_b)
   );

   assign w_start    = w_rise_a | w_rise_b;
   assign w_new_move = w_rise_b ? decode_b(i_stick_up, i_stick_down, i_stick_left, i_stick_right) : 6'b000001;

   // next-state: stun abort, start from idle, connect detection, frame countdown
   always_comb begin
      w_state  = r_state;
      w_cnt    = r_cnt;
      w_move   = r_move;
      w_conn   = r_conn;
      w_strobe = 1'b0;
`ifdef ATTACK_BUFFER_EN
      w_buf_v    = r_buf_v;
      w_buf_move = r_buf_move;
`endif
      if (i_stunned) begin
         w_state = ST_IDLE;
         w_cnt   = 8'd0;
         w_move  = '0;
         w_conn  = 1'b0;
`ifdef ATTACK_BUFFER_EN
         w_buf_v    = 1'b0;
         w_buf_move = '0;
`endif
      end else if (r_state == ST_IDLE) begin
         if (w_start) begin
            w_state = ST_STARTUP;
            w_cnt   = startup_of(w_new_move);
            w_move  = w_new_move;
            w_conn  = 1'b0;
         end
      end else begin
         if (r_state == ST_ACTIVE && i_hit && !r_conn) begin
            w_strobe = 1'b1;
            w_conn   = 1'b1;
         end
`ifdef ATTACK_BUFFER_EN
         if (r_state == ST_RECOVERY && w_start && !r_buf_v) begin
            w_buf_v    = 1'b1;
            w_buf_move = w_new_move;
         end
`endif
         if (i_frame_tick) begin
            if (r_cnt > 8'd1) begin
               w_cnt = r_cnt - 8'd1;
            end else if (r_state == ST_STARTUP) begin
               w_state = ST_ACTIVE;
               w_cnt   = active_of(r_move);
            end else if (r_state == ST_ACTIVE) begin
               w_state = ST_RECOVERY;
               w_cnt   = recovery_of(r_move);
            end else begin
               w_state = ST_IDLE;
               w_cnt   = 8'd0;
               w_move  = '0;
               w_conn  = 1'b0;
`ifdef ATTACK_BUFFER_EN
               if (w_buf_v) begin
                  w_state    = ST_STARTUP;
                  w_move     = w_buf_move;
                  w_cnt      = startup_of(w_buf_move);
                  w_buf_v    = 1'b0;
                  w_buf_move = '0;
               end
`endif
            end
         end
      end
   end

   // state, counter, latched move and connect flags
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 8'd0;
         r_move   <= '0;
         r_conn   <= 1'b0;
         r_strobe <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_cnt    <= w_cnt;
         r_move   <= w_move;
         r_conn   <= w_conn;
         r_strobe <= w_strobe;
      end
   end

`ifdef ATTACK_BUFFER_EN
   // one-deep buffer for a press seen during recovery
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_buf_v    <= 1'b0;
         r_buf_move <= '0;
      end else begin
         r_buf_v    <= w_buf_v;
         r_buf_move <= w_buf_move;
      end
   end
`endif

   // attack word assembled purely from registered state
   always_comb begin
      w_word              = '0;
      w_word[CONNECT]     = r_strobe;
      w_word[BUSY]        = r_state != ST_IDLE;
      w_word[NEUTRAL_B:A] = r_move;
   end

   assign o_attack = w_word;

endmodule
